// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle control FSM for a CR16-style CPU.
// Steps the datapath through fetch, decode, execute, memory and writeback.
// Only one instruction is in flight at a time.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   FETCH  | PC addresses the RAM; the read data arrives next cycle
//   DECODE | RAM data is valid; load the instruction register
//   EXEC   | ALU, LUI and NOP complete; PC += 1
//   MEM_RD | Rsrc addresses the RAM for a LOAD
//   MEM_WR | single-cycle store to [Rsrc]; PC += 1
//   BRANCH | Bcond / Jcond / JAL resolve; PC is redirected or advanced
//   WB     | LOAD data is written to Rdest; PC += 1
//
// Every output is registered. The values for a state are computed on the
// clock edge that enters that state, so each output is stable for the whole
// state. Reset forces FETCH and clears every output at once. This abandons
// any register or memory write that was in progress.
module cpu_controller #(
  parameter int PSR_W    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          OpCode,
  input  logic [3:0]          Rdest,
  input  logic [3:0]          ImmHi_OpExt,
  input  logic [PSR_W-1:0]    psr,
  output logic                instr_en,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic                mem_addr_sel,
  output logic                mem_wr_en,
  output logic                alu_b_sel,
  output logic                imm_sext,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                psr_en,
  output logic                reg_wr_en,
  output logic [1:0]          reg_wr_sel,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_BRANCH = 3'd5,
    S_WB     = 3'd6
  } state_t;

  // JAL asks the ALU to pass PC+1 through, using the MOV function code.
  localparam logic [3:0] FN_MOV = 4'hD;
  localparam logic [3:0] FN_CMP = 4'hB;

  state_t                r_state;
  logic                  r_instr_en;
  logic                  r_pc_en;
  logic [1:0]            r_pc_sel;
  logic                  r_mem_addr_sel;
  logic                  r_mem_wr_en;
  logic                  r_alu_b_sel;
  logic                  r_imm_sext;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic                  r_psr_en;
  logic                  r_reg_wr_en;
  logic [1:0]            r_reg_wr_sel;

  state_t                w_state_nxt;
  logic                  w_rtype;
  logic [3:0]            w_fn;
  logic                  w_alu_valid;
  logic                  w_flag_fam;
  logic                  w_is_cmp;
  logic                  w_sext;
  logic                  w_is_lui;
  logic                  w_is_load;
  logic                  w_is_stor;
  logic                  w_is_bcond;
  logic                  w_is_jcond;
  logic                  w_is_jal;
  logic                  w_cond_true;

  // These are the ALU function codes that the datapath implements. Any other code becomes a NOP.
  function automatic logic fn_defined(input logic [3:0] f);
    case (f)
      4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // The ADD, SUB and CMP families are the only functions that update the flags.
  function automatic logic fn_sets_flags(input logic [3:0] f);
    case (f)
      4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign w_rtype    = (OpCode == 4'b0000);
  assign w_fn       = w_rtype ? ImmHi_OpExt : OpCode;
  assign w_flag_fam = fn_sets_flags(w_fn);
  assign w_is_cmp   = (w_fn == FN_CMP);
  // Logical immediates are zero-extended. Arithmetic, compare and move immediates are sign-extended.
  assign w_sext     = !w_rtype && w_alu_valid &&
                      (w_fn != 4'h1) && (w_fn != 4'h2) && (w_fn != 4'h3);

  // Classify the instruction from its opcode and extension fields.
  always_comb begin
    w_alu_valid = 1'b0;
    w_is_lui    = 1'b0;
    w_is_load   = 1'b0;
    w_is_stor   = 1'b0;
    w_is_bcond  = 1'b0;
    w_is_jcond  = 1'b0;
    w_is_jal    = 1'b0;
    case (OpCode)
      4'b0000: w_alu_valid = fn_defined(ImmHi_OpExt);
      4'b0100: begin
        case (ImmHi_OpExt)
          4'b0000: w_is_load  = 1'b1;
          4'b0100: w_is_stor  = 1'b1;
          4'b1000: w_is_jal   = 1'b1;
          4'b1100: w_is_jcond = 1'b1;
          default: ;
        endcase
      end
      4'b1100: w_is_bcond = 1'b1;
      4'b1111: w_is_lui   = 1'b1;
      default: w_alu_valid = fn_defined(OpCode);
    endcase
  end

  // Evaluate the branch condition held in Rdest against the flags {N,Z,F,L,C}.
  always_comb begin
    w_cond_true = 1'b0;
    case (Rdest)
      4'h0: w_cond_true =  psr[3];
      4'h1: w_cond_true = !psr[3];
      4'h2: w_cond_true =  psr[0];
      4'h3: w_cond_true = !psr[0];
      4'h4: w_cond_true =  psr[1];
      4'h5: w_cond_true = !psr[1];
      4'h6: w_cond_true =  psr[4];
      4'h7: w_cond_true = !psr[4];
      4'h8: w_cond_true =  psr[2];
      4'h9: w_cond_true = !psr[2];
      4'hA: w_cond_true = !psr[1] && !psr[3];
      4'hB: w_cond_true =  psr[1] ||  psr[3];
      4'hC: w_cond_true = !psr[4] && !psr[3];
      4'hD: w_cond_true =  psr[4] ||  psr[3];
      4'hE: w_cond_true = 1'b1;
      default: w_cond_true = 1'b0;
    endcase
  end

  // Choose the next state from the current state and the instruction class.
  always_comb begin
    w_state_nxt = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_load)                          w_state_nxt = S_MEM_RD;
        else if (w_is_stor)                     w_state_nxt = S_MEM_WR;
        else if (w_is_bcond || w_is_jcond || w_is_jal) w_state_nxt = S_BRANCH;
        else                                    w_state_nxt = S_EXEC;
      end
      S_MEM_RD: w_state_nxt = S_WB;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // Register the state and set the registered outputs for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_FETCH;
      r_instr_en     <= 1'b0;
      r_pc_en        <= 1'b0;
      r_pc_sel       <= 2'd0;
      r_mem_addr_sel <= 1'b0;
      r_mem_wr_en    <= 1'b0;
      r_alu_b_sel    <= 1'b0;
      r_imm_sext     <= 1'b0;
      r_alu_op       <= '0;
      r_psr_en       <= 1'b0;
      r_reg_wr_en    <= 1'b0;
      r_reg_wr_sel   <= 2'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_instr_en     <= 1'b0;
      r_pc_en        <= 1'b0;
      r_pc_sel       <= 2'd0;
      r_mem_addr_sel <= 1'b0;
      r_mem_wr_en    <= 1'b0;
      r_alu_b_sel    <= 1'b0;
      r_imm_sext     <= 1'b0;
      r_alu_op       <= '0;
      r_psr_en       <= 1'b0;
      r_reg_wr_en    <= 1'b0;
      r_reg_wr_sel   <= 2'd0;
      case (w_state_nxt)
        S_DECODE: r_instr_en <= 1'b1;
        S_EXEC: begin
          r_pc_en <= 1'b1;
          if (w_is_lui) begin
            r_reg_wr_en  <= 1'b1;
            r_reg_wr_sel <= 2'd2;
            r_alu_b_sel  <= 1'b1;
            r_alu_op     <= ALU_OP_W'(OpCode);
          end else if (w_alu_valid) begin
            r_reg_wr_en <= !w_is_cmp;
            r_psr_en    <= w_flag_fam;
            r_alu_b_sel <= !w_rtype;
            r_imm_sext  <= w_sext;
            r_alu_op    <= ALU_OP_W'(w_fn);
          end
        end
        S_MEM_RD: r_mem_addr_sel <= 1'b1;
        S_WB: begin
          r_reg_wr_en  <= 1'b1;
          r_reg_wr_sel <= 2'd1;
          r_pc_en      <= 1'b1;
        end
        S_MEM_WR: begin
          r_mem_addr_sel <= 1'b1;
          r_mem_wr_en    <= 1'b1;
          r_pc_en        <= 1'b1;
        end
        S_BRANCH: begin
          r_pc_en <= 1'b1;
          if (w_is_jal) begin
            r_pc_sel    <= 2'd2;
            r_reg_wr_en <= 1'b1;
            r_alu_op    <= ALU_OP_W'(FN_MOV);
          end else if (w_cond_true) begin
            r_pc_sel <= w_is_bcond ? 2'd1 : 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_en     = r_instr_en;
  assign pc_en        = r_pc_en;
  assign pc_sel       = r_pc_sel;
  assign mem_addr_sel = r_mem_addr_sel;
  assign mem_wr_en    = r_mem_wr_en;
  assign alu_b_sel    = r_alu_b_sel;
  assign imm_sext     = r_imm_sext;
  assign alu_op       = r_alu_op;
  assign psr_en       = r_psr_en;
  assign reg_wr_en    = r_reg_wr_en;
  assign reg_wr_sel   = r_reg_wr_sel;
  assign state_dbg    = r_state;

endmodule
